// File: rtl/iddmm_task_loader.sv
// Streams latched x/y/m operands into the IDDMM core operand RAM, requests a core task
// and collects the K-bit result stream into res. Optional word-count check: IDDMM_LOADER_WORDCHECK_EN.
module iddmm_task_loader #(
  parameter int K = 128,
  parameter int N = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic [K*N-1:0]        x,
  input  logic [K*N-1:0]        y,
  input  logic [K*N-1:0]        m,
  input  logic [K-1:0]          m1,
  output logic                  busy,
  output logic                  done,
  output logic [K*N-1:0]        res,
  output logic                  err,
  output logic [2:0]            wr_ena,
  output logic [$clog2(N)-1:0]  wr_addr,
  output logic [K-1:0]          wr_x,
  output logic [K-1:0]          wr_y,
  output logic [K-1:0]          wr_m,
  output logic [K-1:0]          wr_m1,
  output logic                  task_req,
  input  logic                  task_end,
  input  logic                  task_grant,
  input  logic [K-1:0]          task_res
);

  localparam int AW = $clog2(N);
  localparam int CW = $clog2(N + 2);
  localparam logic [CW-1:0] CNT_N   = CW'(N);
  localparam logic [CW-1:0] CNT_MAX = CW'(N + 1);

  typedef enum logic [1:0] {IDLE, LOAD, GAP, WAIT} state_t;

  state_t          state_q, state_d;
  logic [K*N-1:0]  x_sh, y_sh, m_sh;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            accept, last_addr;

  assign busy      = (state_q != IDLE);
  assign accept    = (state_q == IDLE) && req;
  assign last_addr = (wr_addr == AW'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_nx  = cnt;
    // Count saturates one past N so an excess is still distinguishable from N.
    if (task_grant && cnt != CNT_MAX) cnt_nx = cnt + CW'(1);
    case (state_q)
      IDLE:    if (req) state_d = LOAD;
      LOAD:    if (last_addr) state_d = GAP;
      GAP:     state_d = WAIT;
      WAIT:    if (task_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_sh     <= '0;
      y_sh     <= '0;
      m_sh     <= '0;
      wr_ena   <= '0;
      wr_addr  <= '0;
      wr_x     <= '0;
      wr_y     <= '0;
      wr_m     <= '0;
      wr_m1    <= '0;
      task_req <= 1'b0;
      done     <= 1'b0;
      res      <= '0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: if (req) begin
          // Word 0 goes out now; the shifters hold the remaining words.
          wr_x    <= x[K-1:0];
          wr_y    <= y[K-1:0];
          wr_m    <= m[K-1:0];
          x_sh    <= x >> K;
          y_sh    <= y >> K;
          m_sh    <= m >> K;
          wr_m1   <= m1;
          wr_ena  <= 3'b111;
          wr_addr <= '0;
          res     <= '0;
          cnt     <= '0;
        end
        LOAD: begin
          if (last_addr) begin
            wr_ena <= 3'b000;
          end else begin
            wr_addr <= wr_addr + AW'(1);
            wr_x    <= x_sh[K-1:0];
            wr_y    <= y_sh[K-1:0];
            wr_m    <= m_sh[K-1:0];
            x_sh    <= x_sh >> K;
            y_sh    <= y_sh >> K;
            m_sh    <= m_sh >> K;
          end
        end
        GAP: task_req <= 1'b1;
        WAIT: begin
          if (task_grant) begin
            if (cnt < CNT_N) res <= {task_res, res[K*N-1:K]};
            cnt <= cnt_nx;
          end
          if (task_end) begin
            task_req <= 1'b0;
            done     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef IDDMM_LOADER_WORDCHECK_EN
  always_ff @(posedge clk) begin
    if (rst)                                 err <= 1'b0;
    else if (accept)                         err <= 1'b0;
    else if (state_q == WAIT && task_end)    err <= (cnt_nx != CNT_N);
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_iddmm_task_loader.sv
// Directed bench for iddmm_task_loader: load sequence, result collection, req/reset corner cases.
module tb_iddmm_task_loader;
  localparam int K = 128;
  localparam int N = 16;
  localparam int AW = $clog2(N);
`ifdef IDDMM_LOADER_WORDCHECK_EN
  localparam logic WC = 1'b1;
`else
  localparam logic WC = 1'b0;
`endif
  localparam logic [K-1:0] X3  = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [K-1:0] M1V = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;

  logic clk = 1'b0;
  logic rst, req, task_end, task_grant;
  logic [K*N-1:0] x, y, m, res;
  logic [K-1:0] m1, task_res, wr_x, wr_y, wr_m, wr_m1;
  logic busy, done, err, task_req;
  logic [2:0] wr_ena;
  logic [AW-1:0] wr_addr;

  int n_tests = 0;
  int n_fail  = 0;

  iddmm_task_loader #(.K(K), .N(N)) dut (
    .clk(clk), .rst(rst), .req(req), .x(x), .y(y), .m(m), .m1(m1),
    .busy(busy), .done(done), .res(res), .err(err),
    .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_x(wr_x), .wr_y(wr_y), .wr_m(wr_m), .wr_m1(wr_m1),
    .task_req(task_req), .task_end(task_end), .task_grant(task_grant), .task_res(task_res)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [K-1:0] act, input logic [K-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [K-1:0] xw(input int i);
    return (i == 3) ? X3 : {4{32'h11110000 | 32'(i)}};
  endfunction
  function automatic logic [K-1:0] yw(input int i);
    return {4{32'hA5A50000 | 32'(i)}};
  endfunction
  function automatic logic [K-1:0] mw(input int i);
    return {4{32'h5A5A0000 | 32'(i)}};
  endfunction

  task automatic chk_res(input string tag, input int ngood);
    for (int i = 0; i < N; i++)
      chk(tag, res[i*K +: K], (i < ngood) ? K'(i + 1) : '0);
  endtask

  // Entered at T+1 (req accepted on the previous edge); leaves at T+18 with task_req checked.
  task automatic do_load(input bit poke);
    for (int i = 0; i < N; i++) begin
      chk("wr_ena", K'(wr_ena), K'(3'b111));
      chk("wr_addr", K'(wr_addr), K'(i));
      chk("wr_x", wr_x, xw(i));
      chk("wr_y", wr_y, yw(i));
      chk("wr_m", wr_m, mw(i));
      chk("wr_m1", wr_m1, M1V);
      chk("busy_load", K'(busy), K'(1));
      req = poke && (i == 4);
      tick();
    end
    req = 1'b0;
    chk("wr_ena_gap", K'(wr_ena), '0);
    chk("task_req_gap", K'(task_req), '0);
    chk("busy_gap", K'(busy), K'(1));
    tick();
    chk("task_req_wait", K'(task_req), K'(1));
  endtask

  // Issues ngr grants (task_res = i+1); task_end rides on the last grant or follows alone.
  task automatic do_core(input int ngr, input bit end_on_last, input bit poke);
    for (int i = 0; i < ngr; i++) begin
      task_grant = 1'b1;
      task_res   = K'(i + 1);
      task_end   = end_on_last && (i == ngr - 1);
      req        = poke && (i == 2);
      tick();
      if (!(end_on_last && i == ngr - 1)) chk("no_done_wait", K'(done), '0);
    end
    task_grant = 1'b0;
    task_res   = '0;
    req        = 1'b0;
    if (!end_on_last) begin
      task_end = 1'b1;
      tick();
    end
    task_end = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; task_end = 1'b0; task_grant = 1'b0; task_res = '0;
    m1 = M1V;
    for (int i = 0; i < N; i++) begin
      x[i*K +: K] = xw(i);
      y[i*K +: K] = yw(i);
      m[i*K +: K] = mw(i);
    end
    tick(); tick();
    rst = 1'b0;
    chk("rst_busy", K'(busy), '0);
    chk("rst_done", K'(done), '0);
    chk("rst_err", K'(err), '0);
    chk("rst_task_req", K'(task_req), '0);
    chk("rst_wr_ena", K'(wr_ena), '0);
    chk("rst_wr_addr", K'(wr_addr), '0);
    chk("rst_wr_x", wr_x, '0);
    chk("rst_wr_m1", wr_m1, '0);
    chk_res("rst_res", 0);

    // Core handshake outside WAIT has no effect.
    task_grant = 1'b1; task_end = 1'b1; task_res = '1;
    tick();
    task_grant = 1'b0; task_end = 1'b0; task_res = '0;
    chk("idle_done", K'(done), '0);
    chk_res("idle_res", 0);

    // Run 1: full load with req poked in LOAD and WAIT, 16 grants, end on last.
    req = 1'b1; tick(); req = 1'b0;
    do_load(1'b1);
    do_core(N, 1'b1, 1'b1);
    chk("r1_done", K'(done), K'(1));
    chk("r1_task_req", K'(task_req), '0);
    chk("r1_busy", K'(busy), '0);
    chk("r1_err", K'(err), '0);
    chk_res("r1_res", N);

    // Run 2: req held at the done cycle starts a new load; reset mid-WAIT aborts it.
    req = 1'b1; tick(); req = 1'b0;
    chk("r2_done_once", K'(done), '0);
    chk_res("r2_res_clr", 0);
    do_load(1'b0);
    for (int i = 0; i < 3; i++) begin
      task_grant = 1'b1; task_res = K'(i + 1); tick();
    end
    task_grant = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    chk("abort_task_req", K'(task_req), '0);
    chk("abort_busy", K'(busy), '0);
    chk("abort_done", K'(done), '0);
    chk_res("abort_res", 0);
    tick();
    chk("abort_done2", K'(done), '0);

    // Run 3: only 15 grants, task_end alone afterwards.
    req = 1'b1; tick(); req = 1'b0;
    do_load(1'b0);
    do_core(N - 1, 1'b0, 1'b0);
    chk("r3_done", K'(done), K'(1));
    chk("r3_err", K'(err), K'(WC));
    tick();
    chk("r3_done_off", K'(done), '0);
    chk("r3_err_hold", K'(err), K'(WC));

    // Run 4: correct run clears err.
    req = 1'b1; tick(); req = 1'b0;
    chk("r4_err_clr", K'(err), '0);
    do_load(1'b0);
    do_core(N, 1'b1, 1'b0);
    chk("r4_done", K'(done), K'(1));
    chk("r4_err", K'(err), '0);
    chk_res("r4_res", N);

    // Run 5: two excess grants must not disturb res.
    tick();
    req = 1'b1; tick(); req = 1'b0;
    do_load(1'b0);
    do_core(N + 2, 1'b1, 1'b0);
    chk("r5_done", K'(done), K'(1));
    chk("r5_err", K'(err), K'(WC));
    chk_res("r5_res", N);
    tick();
    chk("r5_busy", K'(busy), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
